mult_seq_ctrl: RTL and testbench

Iterative multiply controller. It computes one W×W product by time-sharing a single (W/2)×(W/2) multiplier core over four cycles, accumulating the shifted partial products (ll, lh, hl, hh). The core is instantiated outside this block and connected through the mul_* ports, so exact and approximate core variants can be swapped without changing the controller. It sits between an operand source and a result sink, with valid/ready handshakes on both sides.

---
 rtl/mult_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_mult_seq_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// Iterative WxW multiply controller: one product is built from four passes through an
// external (W/2)x(W/2) core, summing the shifted partial products into r_acc.
//   state  | meaning
//   S_IDLE | waiting for an operand pair, in_ready high
//   S_MUL  | one partial product accumulated per cycle, r_step selects which
//   S_DONE | result presented on p, held until the sink takes it
module mult_seq_ctrl #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   p,
  output logic [W/2-1:0]   mul_a,
  output logic [W/2-1:0]   mul_b,
  input  logic [W-1:0]     mul_p,
  output logic             busy
);

  localparam int H = W / 2;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t         r_state;
  logic [1:0]     r_step;
  logic [W-1:0]   r_ra;
  logic [W-1:0]   r_rb;
  logic [2*W-1:0] r_acc;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_busy;

  logic [2*W-1:0] w_pp;
  logic [2*W-1:0] w_term;
  logic [H-1:0]   w_mul_a;
  logic [H-1:0]   w_mul_b;

  assign w_pp = {{W{1'b0}}, mul_p};

  // step[1] picks the a half, step[0] the b half: ll, lh, hl, hh
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    if (r_state == S_MUL) begin
      w_mul_a = r_step[1] ? r_ra[W-1:H] : r_ra[H-1:0];
      w_mul_b = r_step[0] ? r_rb[W-1:H] : r_rb[H-1:0];
    end
  end

  always_comb begin
    w_term = w_pp;
    case (r_step)
      2'd1, 2'd2: w_term = w_pp << H;
      2'd3:       w_term = w_pp << (2 * H);
      default:    w_term = w_pp;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_step      <= '0;
      r_ra        <= '0;
      r_rb        <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_ra       <= a;
            r_rb       <= b;
            r_acc      <= '0;
            r_step     <= '0;
            r_state    <= S_MUL;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_MUL: begin
          // sum wraps modulo 2^(2W); an approximate core may overflow it
          r_acc  <= r_acc + w_term;
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign p         = r_acc;
  assign mul_a     = w_mul_a;
  assign mul_b     = w_mul_b;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: vector table plus scoreboard of expected products,
// with hand sequences for backpressure, back-to-back operation and mid-operation reset.
module tb_mult_seq_ctrl;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic           core_stub = 1'b0;
  logic [W-1:0]   a_i = '0;
  logic [W-1:0]   b_i = '0;
  logic           in_ready;
  logic           out_valid;
  logic           busy;
  logic [2*W-1:0] p;
  logic [W/2-1:0] mul_a;
  logic [W/2-1:0] mul_b;
  logic [W-1:0]   mul_p;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        stub;
    logic [15:0] exp_p;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  // exact core, or a stub that always answers 8'hFF
  assign mul_p = core_stub ? 8'hFF : 8'(8'(mul_a) * 8'(mul_b));

  mult_seq_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .busy      (busy)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  function automatic logic [15:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic stub);
    int unsigned s;
    if (stub) s = 32'hFF + 2 * (32'hFF << 4) + (32'hFF << 8);
    else      s = 32'(ma) * 32'(mb);
    return 16'(s);
  endfunction

  // scoreboard: push on accepted operands, pop on result transfer
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready)
      exp_q.push_back(model(a_i, b_i, core_stub));
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_result", 32'(out_valid), 32'(0));
      else                   check("sb_p", 32'(p), 32'(exp_q.pop_front()));
    end
  end

  // call at posedge+2; returns at posedge+2 after the accepting edge
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tbv, input logic stub);
    bit ok = 1'b0;
    a_i = ta; b_i = tbv; core_stub = stub; in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (in_ready === 1'b1);
    end
    check("accept_timeout", 32'(ok), 32'(1));
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input logic [7:0] ta, input logic [7:0] tbv, input logic stub,
                         input logic [15:0] exp_p, input string tag);
    logic [3:0] ea, eb;
    out_ready = 1'b1;
    start_op(ta, tbv, stub);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ea = (k < 2) ? ta[3:0] : ta[7:4];
      eb = (k == 0 || k == 2) ? tbv[3:0] : tbv[7:4];
      check({tag, "_mul_a"}, 32'(mul_a), 32'(ea));
      check({tag, "_mul_b"}, 32'(mul_b), 32'(eb));
      check({tag, "_early_valid"}, 32'(out_valid), 32'(0));
      check({tag, "_busy"}, 32'(busy), 32'(1));
    end
    @(negedge clk);
    check({tag, "_out_valid"}, 32'(out_valid), 32'(1));
    check({tag, "_p"}, 32'(p), 32'(exp_p));
    check({tag, "_done_mul_a"}, 32'(mul_a), 32'(0));
    @(posedge clk); #2;
    @(negedge clk);
    check({tag, "_idle_ready"}, 32'(in_ready), 32'(1));
    check({tag, "_idle_busy"}, 32'(busy), 32'(0));
    check({tag, "_idle_p_hold"}, 32'(p), 32'(exp_p));
    @(posedge clk); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc_cyc[$];
    int res_cnt;

    vecs[0] = '{8'h12, 8'h34, 1'b0, 16'h03A8};
    vecs[1] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[2] = '{8'h00, 8'hA5, 1'b0, 16'h0000};
    vecs[3] = '{8'h12, 8'h34, 1'b1, 16'h1FDF};
    vecs[4] = '{8'h03, 8'h05, 1'b0, 16'h000F};
    vecs[5] = '{8'h80, 8'h02, 1'b0, 16'h0100};
    vecs[6] = '{8'h0F, 8'hF0, 1'b0, 16'h0E10};

    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_p", 32'(p), 32'(0));
    check("rst_mul_a", 32'(mul_a), 32'(0));
    check("rst_mul_b", 32'(mul_b), 32'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #2;

    for (int v = 0; v < 7; v++)
      run_vec(vecs[v].a, vecs[v].b, vecs[v].stub, vecs[v].exp_p, $sformatf("vec%0d", v));

    // backpressure: sink stalls 3 cycles while a new operand is offered
    out_ready = 1'b0;
    start_op(8'h5A, 8'h0C, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = (out_valid === 1'b1);
    end
    check("bp_valid_timeout", 32'(ok), 32'(1));
    @(posedge clk); #2;
    a_i = 8'h01; b_i = 8'h01; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'(1));
      check("bp_p", 32'(p), 32'(16'h0438));
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_busy", 32'(busy), 32'(1));
      @(posedge clk); #2;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #2;
    @(negedge clk);
    check("bp_after_valid", 32'(out_valid), 32'(0));
    check("bp_after_ready", 32'(in_ready), 32'(1));
    check("bp_after_busy", 32'(busy), 32'(0));
    check("bp_after_p", 32'(p), 32'(16'h0438));
    check("bp_queue_empty", 32'(exp_q.size()), 32'(0));
    @(posedge clk); #2;

    // back-to-back: in_valid held high, sink always ready
    out_ready = 1'b1; core_stub = 1'b0;
    a_i = 8'h03; b_i = 8'h05; in_valid = 1'b1;
    res_cnt = 0;
    for (int c = 0; c < 30 && res_cnt < 2; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc_cyc.push_back(c);
      if (out_valid) begin
        check($sformatf("b2b_p%0d", res_cnt), 32'(p), (res_cnt == 0) ? 32'h000F : 32'h003F);
        res_cnt++;
      end
      @(posedge clk); #2;
      if (acc_cyc.size() == 1) begin
        a_i = 8'h07; b_i = 8'h09;
      end
    end
    in_valid = 1'b0;
    check("b2b_results", 32'(res_cnt), 32'(2));
    check("b2b_accepts", 32'(acc_cyc.size()), 32'(2));
    if (acc_cyc.size() >= 2)
      check("b2b_accept_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'(6));
    @(posedge clk); #2;

    // asynchronous reset during step2 aborts the operation
    out_ready = 1'b1;
    start_op(8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    check("mid_rst_step2_mul_a", 32'(mul_a), 32'(1));
    check("mid_rst_step2_mul_b", 32'(mul_b), 32'(4));
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_p", 32'(p), 32'(0));
    check("mid_rst_mul_a", 32'(mul_a), 32'(0));
    check("mid_rst_mul_b", 32'(mul_b), 32'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'(1));
    check("mid_rst_no_result", 32'(out_valid), 32'(0));
    @(posedge clk); #2;
    run_vec(8'hA7, 8'h3C, 1'b0, 16'h2724, "post_rst");

    check("sb_drained", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
